// File: rtl/imgproc_pkg.sv
// Shared image-processing constants: Q11 fixed point, ratio saturation,
// quadrant sideband layout and arctan stage latency.
package imgproc_pkg;

    localparam int ONE_Q11    = 2048;
    localparam int RATIO_SAT  = 131071;
    localparam int ARCTAN_LAT = 36;

    localparam int SIDE_W   = 4;
    localparam int SIDE_SX  = 3;
    localparam int SIDE_SY  = 2;
    localparam int SIDE_GXZ = 1;
    localparam int SIDE_GYZ = 0;

    typedef logic [SIDE_W-1:0] side_t;

endpackage

// File: rtl/delay_line.sv
// Plain register shift chain, DEPTH stages of W bits, synchronous active-low reset.
module delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/grad_ratio.sv
// Sobel gradients to saturated Q11 slope |gy|/|gx| via a fully pipelined restoring
// divider, with quadrant sidebands delayed to line up with the arctan output.
module grad_ratio #(
    parameter int GW        = 11,
    parameter int FRAC      = 11,
    parameter int OW        = 18,
    parameter int RATIO_SAT = imgproc_pkg::RATIO_SAT,
    parameter int SIDE_DLY  = imgproc_pkg::ARCTAN_LAT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            valid_i,
    input  logic signed [GW-1:0]            gx_i,
    input  logic signed [GW-1:0]            gy_i,
    output logic                            valid_o,
    output logic signed [OW-1:0]            ratio_o,
    output logic                            side_vld_o,
    output logic [imgproc_pkg::SIDE_W-1:0]  side_o
);

    import imgproc_pkg::*;

    localparam int N = GW - 1 + FRAC;
    localparam logic [OW-1:0] SAT_OUT = OW'(RATIO_SAT);

    logic [GW-1:0] abs_gx;
    logic [GW-1:0] abs_gy;

    assign abs_gx = gx_i[GW-1] ? (~gx_i + 1'b1) : gx_i;
    assign abs_gy = gy_i[GW-1] ? (~gy_i + 1'b1) : gy_i;

    // Index 0 is the input stage; the numerator is held pre-shifted and shares its
    // register with the quotient: each divider stage consumes the MSB and shifts a q bit in.
    logic [GW-1:0] rem_q  [N+1];
    logic [N-1:0]  nq_q   [N+1];
    logic [GW-1:0] ax_q   [N+1];
    logic          vld_q  [N+1];
    side_t         side_q [N+1];

    logic [GW-1:0] rem_d  [N];
    logic [N-1:0]  nq_d   [N];

    always_comb begin : div_step
        logic [GW:0] trial;
        logic        take;
        trial = '0;
        take  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            trial    = {rem_q[i], nq_q[i][N-1]};
            take     = (trial >= {1'b0, ax_q[i]});
            rem_d[i] = take ? (trial[GW-1:0] - ax_q[i]) : trial[GW-1:0];
            nq_d[i]  = {nq_q[i][N-2:0], take};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i <= N; i++) begin
                rem_q[i]  <= '0;
                nq_q[i]   <= '0;
                ax_q[i]   <= '0;
                vld_q[i]  <= 1'b0;
                side_q[i] <= '0;
            end
        end else begin
            rem_q[0]  <= '0;
            nq_q[0]   <= N'({abs_gy, {FRAC{1'b0}}});
            ax_q[0]   <= abs_gx;
            vld_q[0]  <= valid_i;
            side_q[0] <= {gx_i[GW-1], gy_i[GW-1], gx_i == '0, gy_i == '0};
            for (int unsigned i = 0; i < N; i++) begin
                rem_q[i+1]  <= rem_d[i];
                nq_q[i+1]   <= nq_d[i];
                ax_q[i+1]   <= ax_q[i];
                vld_q[i+1]  <= vld_q[i];
                side_q[i+1] <= side_q[i];
            end
        end
    end

    side_t side_r;

    // The divider's own result for ax==0 is meaningless; the zero flags decide instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_o <= 1'b0;
            ratio_o <= '0;
            side_r  <= '0;
        end else begin
            valid_o <= vld_q[N];
            side_r  <= side_q[N];
            if (side_q[N][SIDE_GXZ]) begin
                ratio_o <= side_q[N][SIDE_GYZ] ? '0 : $signed(SAT_OUT);
            end else if (nq_q[N] > N'(RATIO_SAT)) begin
                ratio_o <= $signed(SAT_OUT);
            end else begin
                ratio_o <= $signed(nq_q[N][OW-1:0]);
            end
        end
    end

    delay_line #(
        .W     (SIDE_W + 1),
        .DEPTH (SIDE_DLY)
    ) u_side_dly (
        .clk (clk),
        .rst (rst),
        .d   ({valid_o, side_r}),
        .q   ({side_vld_o, side_o})
    );

endmodule

// File: tb/tb_grad_ratio.sv
// Self-checking bench for grad_ratio: directed corner cases, randomized stream with
// gaps, and mid-stream reset, checked against an arithmetic reference model.
module tb_grad_ratio;

    localparam int GW      = 11;
    localparam int OW      = 18;
    localparam int SAT     = 131071;
    localparam int LAT     = 23;
    localparam int SIDE_LAT = 59;

    logic                  clk;
    logic                  rst;
    logic                  valid_i;
    logic signed [GW-1:0]  gx_i;
    logic signed [GW-1:0]  gy_i;
    logic                  valid_o;
    logic signed [OW-1:0]  ratio_o;
    logic                  side_vld_o;
    logic [3:0]            side_o;

    grad_ratio dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .gx_i       (gx_i),
        .gy_i       (gy_i),
        .valid_o    (valid_o),
        .ratio_o    (ratio_o),
        .side_vld_o (side_vld_o),
        .side_o     (side_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              due;
        logic [OW-1:0]   ratio;
        logic [3:0]      side;
    } exp_t;

    exp_t rq[$];
    exp_t sq[$];
    int   cyc;
    int   n_cmp;
    int   n_bad;

    function automatic logic [OW-1:0] ref_ratio(input int gx, input int gy);
        int ax, ay, q;
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        if (ax == 0) return (ay == 0) ? '0 : OW'(SAT);
        q = (ay * 2048) / ax;
        return (q > SAT) ? OW'(SAT) : OW'(q);
    endfunction

    function automatic logic [3:0] ref_side(input int gx, input int gy);
        return {gx < 0, gy < 0, gx == 0, gy == 0};
    endfunction

    task automatic check_outputs(input logic in_rst);
        logic          ev, esv;
        logic [OW-1:0] er;
        logic [3:0]    es;
        ev  = (rq.size() > 0) && (rq[0].due == cyc);
        esv = (sq.size() > 0) && (sq[0].due == cyc);
        er  = ev  ? rq[0].ratio : '0;
        es  = esv ? sq[0].side  : '0;

        n_cmp++;
        assert (valid_o === ev) else begin
            n_bad++;
            $error("FAIL valid_o cyc=%0d got=%b exp=%b", cyc, valid_o, ev);
        end
        n_cmp++;
        assert (side_vld_o === esv) else begin
            n_bad++;
            $error("FAIL side_vld_o cyc=%0d got=%b exp=%b", cyc, side_vld_o, esv);
        end
        if (ev || !in_rst) begin
            n_cmp++;
            assert (ratio_o === $signed(er)) else begin
                n_bad++;
                $error("FAIL ratio_o cyc=%0d got=%0d exp=%0d", cyc, ratio_o, er);
            end
        end
        if (esv || !in_rst) begin
            n_cmp++;
            assert (side_o === es) else begin
                n_bad++;
                $error("FAIL side_o cyc=%0d got=%b exp=%b", cyc, side_o, es);
            end
        end
        if (ev)  void'(rq.pop_front());
        if (esv) void'(sq.pop_front());
    endtask

    // Drive one cycle, update the model at the sampling edge, check on the falling edge.
    task automatic step(input logic r, input logic v, input int gx, input int gy);
        exp_t e;
        rst     = r;
        valid_i = v;
        gx_i    = GW'(gx);
        gy_i    = GW'(gy);
        @(posedge clk);
        cyc++;
        if (!r) begin
            rq.delete();
            sq.delete();
        end else if (v) begin
            e.ratio = ref_ratio(gx, gy);
            e.side  = ref_side(gx, gy);
            e.due   = cyc + LAT - 1;
            rq.push_back(e);
            e.due   = cyc + SIDE_LAT - 1;
            sq.push_back(e);
        end
        @(negedge clk);
        check_outputs(r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, $urandom_range(0, 2040) - 1020, $urandom_range(0, 2040) - 1020);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int gx, gy;
        cyc   = 0;
        n_cmp = 0;
        n_bad = 0;

        // Reset: outputs checked to zero during reset cycles
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0);

        // Single pulse, wait out both latencies
        step(1'b1, 1'b1, 100, 50);
        idle(SIDE_LAT + 2);

        // Directed corners back to back
        step(1'b1, 1'b1, -200, 200);
        step(1'b1, 1'b1, 3, -1);
        step(1'b1, 1'b1, 0, 5);
        step(1'b1, 1'b1, 0, 0);
        step(1'b1, 1'b1, 1, -1020);
        step(1'b1, 1'b1, -1024, 1020);
        step(1'b1, 1'b1, 5, 0);
        step(1'b1, 1'b1, -1, 1);
        idle(SIDE_LAT + 2);

        // Random stream with random gaps
        sent = 0;
        while (sent < 100) begin
            gx = $urandom_range(0, 2047) - 1024;
            gy = $urandom_range(0, 2040) - 1020;
            if ($urandom_range(0, 15) == 0) gx = 0;
            if ($urandom_range(0, 15) == 0) gy = 0;
            if ($urandom_range(0, 3) != 0) begin
                step(1'b1, 1'b1, gx, gy);
                sent++;
            end else begin
                step(1'b1, 1'b0, gx, gy);
            end
        end
        idle(SIDE_LAT + 2);

        // Mid-stream reset discards ten in-flight samples
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, $urandom_range(1, 1023), $urandom_range(0, 1020));
        end
        step(1'b0, 1'b1, 7, 9);
        step(1'b1, 1'b1, 7, 9);
        idle(SIDE_LAT + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
